instr_fetch_responder: RTL and testbench
========================================

Name: instr_fetch_responder

Overview:
Instruction-memory slave that answers the core's instruction fetch port: it accepts fetch addresses with a req/gnt handshake and returns 32-bit instruction words with a one-cycle rvalid pulse.
It is the memory end of the fetch interface, the eflash/boot-ROM side.
Word storage is a register array preloaded through a backdoor load port by the bench or boot logic.
Programmable access latency and a small outstanding-request queue let fetch-stage stalls be exercised.

Parameters:
ADDR_W, 32, fetch address width
MEM_WORDS, 1024, number of 32-bit words stored
BASE_ADDR, 32'h0000_0000, byte address of word 0
WAIT_CYCLES, 1, grant-to-rvalid latency in cycles (legal range >= 1)
FIFO_DEPTH, 2, maximum outstanding granted requests (legal range >= 1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
instr_req_i  in  1  fetch request
instr_addr_i  in  ADDR_W  fetch byte address, sampled when req & gnt
instr_gnt_o  out  1  request accepted this cycle
instr_rvalid_o  out  1  response valid, one-cycle pulse per granted request
instr_rdata_o  out  32  instruction word, valid with rvalid
instr_err_o  out  1  response error, valid with rvalid
load_we_i  in  1  backdoor word write enable
load_addr_i  in  $clog2(MEM_WORDS)  backdoor word index
load_wdata_i  in  32  backdoor write data
busy_o  out  1  queue non-empty or access in progress

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset state:
  - queue empty, FSM in IDLE, counter 0.
  - gnt, rvalid, err and busy all 0; rdata 32'h0.
  - Memory array is NOT reset.
- Reset mid-operation: all outstanding requests are discarded and produce no rvalid.
- Grant:
  - instr_gnt_o = instr_req_i & (count < FIFO_DEPTH), combinational.
  - No pass-through: a full queue does not grant even if it pops in the same cycle.
  - On req & gnt, push {addr, err_flag}.
- Error flag, computed at push: err_flag = (addr[1:0] != 0) | (addr < BASE_ADDR) | (((addr - BASE_ADDR) >> 2) >= MEM_WORDS).
- Word index: (addr - BASE_ADDR) >> 2, truncated to the index width.
- FSM state IDLE:
  - Leave IDLE when the queue is non-empty at a clock edge, including a push in the previous cycle.
  - Next state ACCESS, cnt = WAIT_CYCLES-1.
- FSM state ACCESS:
  - If cnt != 0: cnt decrements each cycle.
  - If cnt == 0: instr_rvalid_o = 1 and the head entry is popped.
  - After the pop, if the queue still holds an entry (counting a same-cycle push), stay in ACCESS with cnt reloaded to WAIT_CYCLES-1; otherwise go to IDLE.
- Latency and throughput:
  - Request granted in cycle N into an idle block: rvalid in cycle N+WAIT_CYCLES.
  - Back-to-back responses come every WAIT_CYCLES cycles.
  - Responses return strictly in grant order.
- Response data:
  - rdata_o = mem[head index] when err_flag = 0; otherwise 32'h0 with err_o = 1.
  - Outside rvalid, rdata and err are driven 0.
- Backdoor load:
  - load_we_i writes mem[load_addr_i] at the clock edge.
  - A read of the same word in that cycle returns the old value.
  - Load and fetch traffic may run concurrently.
- busy_o = (state != IDLE) | (count != 0).
- Counters: queue pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH+1).

Test Plan:
1. Preload mem[0]=32'h003080B3, mem[1]=32'h403080B3 (WAIT_CYCLES=1). Fetch 0x0 then 0x4 back-to-back. Expect gnt in cycles 0 and 1; rvalid in cycles 1 and 2 with those words; err 0.
2. WAIT_CYCLES=3, FIFO_DEPTH=2. Hold req for addresses 0x0, 0x4, 0x8. Expect gnt 1,1 then 0 until the first pop; rvalid at grant+3, +6, +9; data in order.
3. Fetch 0x2 (misaligned) and 0x1000 (MEM_WORDS=1024, out of range). Expect rvalid with err=1, rdata=0. A following fetch of 0x0 returns mem[0] with err=0.
4. Assert rst_i while 2 requests are outstanding. Expect gnt, rvalid and busy = 0 immediately and no later rvalid. mem[0] keeps its value, checked by a fetch after reset.
5. Backdoor write of mem[0]=32'hDEADBEEF in the same cycle the response for 0x0 is presented. Expect the old value returned; a fetch on the next cycle returns 32'hDEADBEEF.
6. Random req/addr traffic for 10k cycles against a reference queue model. Check one rvalid per gnt, ordering, and that count never exceeds FIFO_DEPTH.

Source files
------------

// File: rtl/instr_fetch_responder.sv
// ----------------------------------------------------------------------------
// instr_fetch_responder
//
// Memory end of the core's instruction fetch interface (eflash / boot-ROM
// side). Fetch addresses are accepted with a req/gnt handshake, queued, and
// answered in grant order with a one-cycle rvalid pulse carrying a 32-bit
// instruction word. Word storage is a register array filled through a
// backdoor load port. The access latency and queue depth are parameters so
// fetch-stage stalls can be exercised.
//
// Handshake semantics:
//   Request side: the core holds instr_req_i/instr_addr_i; a transfer happens
//   in every cycle where instr_req_i & instr_gnt_o are both 1, and the
//   address is sampled in that cycle. Response side: there is no ready;
//   instr_rvalid_o pulses for exactly one cycle per granted request, in
//   grant order, and instr_rdata_o / instr_err_o are only meaningful in that
//   cycle (they are driven to 0 otherwise).
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   instr_req_i      fetch request
//   instr_addr_i     fetch byte address, sampled when req & gnt
//   instr_gnt_o      request accepted this cycle (combinational)
//   instr_rvalid_o   response valid, one-cycle pulse per granted request
//   instr_rdata_o    instruction word, valid with rvalid
//   instr_err_o      response error (misaligned / out of range), with rvalid
//   load_we_i        backdoor word write enable
//   load_addr_i      backdoor word index
//   load_wdata_i     backdoor write data
//   busy_o           queue non-empty or access in progress
// ----------------------------------------------------------------------------
module instr_fetch_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_req_i,
  input  logic [ADDR_W-1:0]            instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                  load_wdata_i,
  output logic                         busy_o
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [WCNT_W-1:0] WAIT_RELOAD = WCNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_C      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WORDS_C     = ADDR_W'(MEM_WORDS);

  // --------------------------------------------------------------------------
  // Types
  // --------------------------------------------------------------------------
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // FSM state kept together in one struct so checkers can bind to fsm_q.
  typedef struct packed {
    state_t              state;
    logic [WCNT_W-1:0]   wcnt;
  } fsm_t;

  // One queued request: resolved word index plus the error verdict, both
  // decided at grant time so the response path is a plain lookup.
  typedef struct packed {
    logic [IDX_W-1:0]    idx;
    logic                err;
  } entry_t;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [31:0] mem [MEM_WORDS];
  entry_t      fifo_q [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  fsm_t              fsm_q;
  logic              rvalid_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_off;
  logic [ADDR_W-1:0] word_off;
  logic              push_err;
  logic [IDX_W-1:0]  push_idx;
  entry_t            push_entry;

  assign addr_off = instr_addr_i - BASE_C;
  assign word_off = addr_off >> 2;

  // Below-base addresses wrap to huge offsets, but the explicit compare keeps
  // the intent obvious and stays correct for any BASE_ADDR.
  assign push_err = (instr_addr_i[1:0] != 2'b00)
                  | (instr_addr_i < BASE_C)
                  | (word_off >= WORDS_C);
  assign push_idx = word_off[IDX_W-1:0];

  assign push_entry.idx = push_idx;
  assign push_entry.err = push_err;

  // --------------------------------------------------------------------------
  // Handshake and queue occupancy
  // --------------------------------------------------------------------------
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_nxt;

  // Grant depends only on the registered count: a full queue never grants,
  // even in a cycle where it pops. Masked by reset so nothing is accepted
  // while the block is held in reset.
  assign instr_gnt_o = instr_req_i & (count_q < DEPTH_C) & ~rst_i;
  assign push        = instr_gnt_o;

  // The response pulse is the pop: the head entry is answered and released
  // in the same cycle.
  assign pop       = rvalid_q;
  assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_nxt;
    end
  end

  // Queue payload carries no reset: entries are only read while counted.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  // --------------------------------------------------------------------------
  // Access FSM
  //
  // IDLE   : leaves as soon as the queue will be non-empty after this edge
  //          (this covers a request granted in the current cycle).
  // ACCESS : counts WAIT_CYCLES-1 down to 0; at 0 the head is answered.
  //          If anything is still queued after that pop (including a push in
  //          the same cycle) the counter reloads, otherwise back to IDLE.
  //
  // rvalid_q is the registered form of (state == ACCESS && wcnt == 0): it is
  // computed from the same next-state decision so the output comes straight
  // from a flop.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q.state <= IDLE;
      fsm_q.wcnt  <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      case (fsm_q.state)
        IDLE: begin
          if (count_nxt != '0) begin
            fsm_q.state <= ACCESS;
            fsm_q.wcnt  <= WAIT_RELOAD;
            rvalid_q    <= (WAIT_RELOAD == '0);
          end else begin
            rvalid_q    <= 1'b0;
          end
        end
        ACCESS: begin
          if (fsm_q.wcnt != '0) begin
            fsm_q.wcnt <= fsm_q.wcnt - WCNT_W'(1);
            rvalid_q   <= (fsm_q.wcnt == WCNT_W'(1));
          end else if (count_nxt != '0) begin
            fsm_q.wcnt <= WAIT_RELOAD;
            rvalid_q   <= (WAIT_RELOAD == '0);
          end else begin
            fsm_q.state <= IDLE;
            fsm_q.wcnt  <= '0;
            rvalid_q    <= 1'b0;
          end
        end
        default: begin
          fsm_q.state <= IDLE;
          fsm_q.wcnt  <= '0;
          rvalid_q    <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Backdoor load. Not reset: contents survive a reset of the fetch logic.
  // A read of the word being written in the same cycle sees the old value,
  // because the write lands on the clock edge that ends the cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (load_we_i) mem[load_addr_i] <= load_wdata_i;
  end

  // --------------------------------------------------------------------------
  // Response path
  // --------------------------------------------------------------------------
  entry_t head;

  assign head = fifo_q[rd_ptr_q];

  assign instr_rvalid_o = rvalid_q;
  assign instr_err_o    = rvalid_q & head.err;
  assign instr_rdata_o  = (rvalid_q && !head.err) ? mem[head.idx] : 32'h0;

  assign busy_o = (fsm_q.state != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_instr_fetch_responder.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_responder
//
// Two instances share clock and reset:
//   k = 0 : WAIT_CYCLES = 1, FIFO_DEPTH = 2
//   k = 1 : WAIT_CYCLES = 3, FIFO_DEPTH = 2
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge. mm[k] mirrors the contents of each instance's memory.
// ----------------------------------------------------------------------------
module tb_instr_fetch_responder;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // DUT signals (index = instance)
  // --------------------------------------------------------------------------
  logic        req    [2];
  logic [31:0] addr   [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];
  logic        lwe    [2];
  logic [9:0]  laddr  [2];
  logic [31:0] lwdata [2];
  logic        busy   [2];

  logic [31:0] mm [2][1024];

  int vectors;
  int miscompares;

  instr_fetch_responder #(
    .ADDR_W(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0),
    .WAIT_CYCLES(1), .FIFO_DEPTH(2)
  ) dut_w1 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(req[0]), .instr_addr_i(addr[0]),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]),
    .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
    .load_we_i(lwe[0]), .load_addr_i(laddr[0]), .load_wdata_i(lwdata[0]),
    .busy_o(busy[0])
  );

  instr_fetch_responder #(
    .ADDR_W(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0),
    .WAIT_CYCLES(3), .FIFO_DEPTH(2)
  ) dut_w3 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(req[1]), .instr_addr_i(addr[1]),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]),
    .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
    .load_we_i(lwe[1]), .load_addr_i(laddr[1]), .load_wdata_i(lwdata[1]),
    .busy_o(busy[1])
  );

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int k, input int idx, input logic [31:0] d);
    lwe[k]    = 1'b1;
    laddr[k]  = 10'(idx);
    lwdata[k] = d;
    next_cycle();
    lwe[k]    = 1'b0;
    mm[k][idx] = d;
  endtask

  task automatic preload_all();
    for (int i = 0; i < 1024; i++) begin
      for (int k = 0; k < 2; k++) begin
        lwe[k]    = 1'b1;
        laddr[k]  = 10'(i);
        lwdata[k] = $urandom;
        mm[k][i]  = lwdata[k];
      end
      next_cycle();
    end
    lwe[0] = 1'b0;
    lwe[1] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    if (r < 6)       a = 32'($urandom_range(0, 15)) << 2;
    else if (r == 6) a = 32'($urandom_range(0, 1023)) << 2;
    else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 8) a = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
    else             a = $urandom;
    return a;
  endfunction

  // --------------------------------------------------------------------------
  // test_reset: all outputs quiet while reset is held, even with req high
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst    = 1'b1;
    req[0] = 1'b1;
    req[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({gnt[k], rvalid[k], err[k], busy[k]} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_ctrl k=%0d: got gnt/rv/err/busy=%b%b%b%b expected 0000",
                 k, gnt[k], rvalid[k], err[k], busy[k]);
      end
      vectors++;
      if (rdata[k] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rdata k=%0d: got %h expected 00000000", k, rdata[k]);
      end
    end
    next_cycle();
    req[0] = 1'b0;
    req[1] = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({gnt[k], rvalid[k], busy[k]} !== 3'b000) begin
        miscompares++;
        $display("FAIL post_reset k=%0d: got gnt/rv/busy=%b%b%b expected 000",
                 k, gnt[k], rvalid[k], busy[k]);
      end
    end
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  // test_back_to_back: WAIT=1, fetch 0x0 then 0x4 in consecutive cycles
  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [31:0] a_tab [4];
    logic        r_tab [4];
    logic        g_exp [4];
    logic        v_exp [4];
    logic [31:0] d_exp [4];
    load_word(0, 0, 32'h0030_80B3);
    load_word(0, 1, 32'h4030_80B3);
    a_tab = '{32'h0, 32'h4, 32'h0, 32'h0};
    r_tab = '{1'b1, 1'b1, 1'b0, 1'b0};
    g_exp = '{1'b1, 1'b1, 1'b0, 1'b0};
    v_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
    d_exp = '{32'h0, 32'h0030_80B3, 32'h4030_80B3, 32'h0};
    for (int c = 0; c < 4; c++) begin
      req[0]  = r_tab[c];
      addr[0] = a_tab[c];
      @(negedge clk);
      vectors++;
      if (gnt[0] !== g_exp[c]) begin
        miscompares++;
        $display("FAIL b2b_gnt cyc=%0d: got %b expected %b", c, gnt[0], g_exp[c]);
      end
      vectors++;
      if (rvalid[0] !== v_exp[c] || rdata[0] !== d_exp[c] || err[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_resp cyc=%0d: got rv=%b data=%h err=%b expected rv=%b data=%h err=0",
                 c, rvalid[0], rdata[0], err[0], v_exp[c], d_exp[c]);
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got busy=%b expected 0", busy[0]);
    end
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  // test_latency: WAIT=3, DEPTH=2, req held for 0x0, 0x4, 0x8
  // Grants expected in cycles 0,1,4; responses in cycles 3,6,9.
  // --------------------------------------------------------------------------
  task automatic test_latency();
    int n = 0;
    int m = 0;
    logic eg, ev, eb;
    for (int c = 0; c < 12; c++) begin
      req[1]  = (n < 3);
      addr[1] = 32'(n) << 2;
      @(negedge clk);
      eg = (c == 0) || (c == 1) || (c == 4);
      ev = (c == 3) || (c == 6) || (c == 9);
      eb = (c >= 1) && (c <= 9);
      vectors++;
      if (gnt[1] !== eg) begin
        miscompares++;
        $display("FAIL lat_gnt cyc=%0d: got %b expected %b", c, gnt[1], eg);
      end
      vectors++;
      if (rvalid[1] !== ev) begin
        miscompares++;
        $display("FAIL lat_rvalid cyc=%0d: got %b expected %b", c, rvalid[1], ev);
      end
      vectors++;
      if (busy[1] !== eb) begin
        miscompares++;
        $display("FAIL lat_busy cyc=%0d: got %b expected %b", c, busy[1], eb);
      end
      if (ev) begin
        vectors++;
        if (rdata[1] !== mm[1][m] || err[1] !== 1'b0) begin
          miscompares++;
          $display("FAIL lat_data cyc=%0d: got %h err=%b expected %h err=0",
                   c, rdata[1], err[1], mm[1][m]);
        end
        m++;
      end
      if (gnt[1] === 1'b1) n++;
      next_cycle();
    end
  endtask

  // --------------------------------------------------------------------------
  // test_error: misaligned, just-out-of-range, last word, word 0 (WAIT=1)
  // --------------------------------------------------------------------------
  task automatic test_error();
    logic [31:0] a_tab [4];
    logic        e_exp [4];
    logic [31:0] d_exp [4];
    a_tab = '{32'h2, 32'h1000, 32'hFFC, 32'h0};
    e_exp = '{1'b1, 1'b1, 1'b0, 1'b0};
    d_exp = '{32'h0, 32'h0, mm[0][1023], mm[0][0]};
    for (int c = 0; c < 6; c++) begin
      req[0]  = (c < 4);
      addr[0] = (c < 4) ? a_tab[c] : 32'h0;
      @(negedge clk);
      vectors++;
      if (gnt[0] !== (c < 4)) begin
        miscompares++;
        $display("FAIL err_gnt cyc=%0d: got %b expected %b", c, gnt[0], (c < 4));
      end
      vectors++;
      if (rvalid[0] !== (c >= 1 && c <= 4)) begin
        miscompares++;
        $display("FAIL err_rvalid cyc=%0d: got %b expected %b", c, rvalid[0], (c >= 1 && c <= 4));
      end
      if (c >= 1 && c <= 4) begin
        vectors++;
        if (err[0] !== e_exp[c-1] || rdata[0] !== d_exp[c-1]) begin
          miscompares++;
          $display("FAIL err_resp addr=%h: got err=%b data=%h expected err=%b data=%h",
                   a_tab[c-1], err[0], rdata[0], e_exp[c-1], d_exp[c-1]);
        end
      end
      next_cycle();
    end
  endtask

  // --------------------------------------------------------------------------
  // test_load_collision: backdoor write of word 0 while its response is out
  // --------------------------------------------------------------------------
  task automatic test_load_collision();
    logic [31:0] old_w;
    old_w   = mm[0][0];
    req[0]  = 1'b1;
    addr[0] = 32'h0;
    next_cycle();
    lwe[0]    = 1'b1;
    laddr[0]  = 10'd0;
    lwdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== old_w) begin
      miscompares++;
      $display("FAIL col_old: got rv=%b data=%h expected rv=1 data=%h", rvalid[0], rdata[0], old_w);
    end
    vectors++;
    if (gnt[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL col_gnt: got %b expected 1", gnt[0]);
    end
    next_cycle();
    mm[0][0] = 32'hDEAD_BEEF;
    lwe[0]   = 1'b0;
    req[0]   = 1'b0;
    @(negedge clk);
    vectors++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL col_new: got rv=%b data=%h expected rv=1 data=deadbeef", rvalid[0], rdata[0]);
    end
    next_cycle();
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  // test_reset_mid: WAIT=3, two outstanding requests discarded by reset
  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      req[1]  = 1'b1;
      addr[1] = 32'(c) << 2;
      @(negedge clk);
      vectors++;
      if (gnt[1] !== 1'b1) begin
        miscompares++;
        $display("FAIL rmid_gnt cyc=%0d: got %b expected 1", c, gnt[1]);
      end
      next_cycle();
    end
    addr[1] = 32'h8;
    rst     = 1'b1;
    @(negedge clk);
    vectors++;
    if ({gnt[1], rvalid[1], busy[1]} !== 3'b000) begin
      miscompares++;
      $display("FAIL rmid_now: got gnt/rv/busy=%b%b%b expected 000", gnt[1], rvalid[1], busy[1]);
    end
    next_cycle();
    rst    = 1'b0;
    req[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (rvalid[1] !== 1'b0 || busy[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL rmid_ghost cyc=%0d: got rv=%b busy=%b expected 0 0", c, rvalid[1], busy[1]);
      end
      next_cycle();
    end
    for (int c = 0; c < 5; c++) begin
      req[1]  = (c == 0);
      addr[1] = 32'h0;
      @(negedge clk);
      vectors++;
      if (rvalid[1] !== (c == 3)) begin
        miscompares++;
        $display("FAIL rmid_refetch_rv cyc=%0d: got %b expected %b", c, rvalid[1], (c == 3));
      end
      if (c == 3) begin
        vectors++;
        if (rdata[1] !== mm[1][0]) begin
          miscompares++;
          $display("FAIL rmid_mem_kept: got %h expected %h", rdata[1], mm[1][0]);
        end
      end
      next_cycle();
    end
  endtask

  // --------------------------------------------------------------------------
  // test_random: random req/addr/load traffic against a reference model.
  // The model predicts each response's cycle from the latency rule
  // resp = max(grant_cycle, previous_resp) + WAIT, and the queue occupancy
  // as the number of granted requests not yet answered.
  // --------------------------------------------------------------------------
  typedef struct {
    int unsigned idx;
    bit          err;
    int          resp;
  } exp_t;

  task automatic test_random(input int k, input int ncyc, input int wait_c, input int depth);
    exp_t exp_q[$];
    exp_t e;
    int   last = -1;
    int   outstanding = 0;
    logic eg, ev, eb;
    logic [31:0] a;
    logic [31:0] ed;
    for (int c = 0; c < ncyc; c++) begin
      bit drain = (c >= ncyc - 20);
      a         = rand_addr();
      req[k]    = !drain && ($urandom_range(0, 99) < 70);
      addr[k]   = a;
      lwe[k]    = ($urandom_range(0, 4) == 0);
      laddr[k]  = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
      lwdata[k] = $urandom;
      @(negedge clk);
      eg = req[k] && (exp_q.size() < depth);
      eb = (exp_q.size() != 0);
      ev = (exp_q.size() != 0) && (exp_q[0].resp == c);
      vectors++;
      if (gnt[k] !== eg) begin
        miscompares++;
        $display("FAIL rnd_gnt k=%0d cyc=%0d: got %b expected %b", k, c, gnt[k], eg);
      end
      vectors++;
      if (busy[k] !== eb) begin
        miscompares++;
        $display("FAIL rnd_busy k=%0d cyc=%0d: got %b expected %b", k, c, busy[k], eb);
      end
      vectors++;
      if (rvalid[k] !== ev) begin
        miscompares++;
        $display("FAIL rnd_rvalid k=%0d cyc=%0d: got %b expected %b", k, c, rvalid[k], ev);
      end
      if (ev) begin
        e  = exp_q.pop_front();
        ed = e.err ? 32'h0 : mm[k][e.idx];
        vectors++;
        if (rdata[k] !== ed || err[k] !== e.err) begin
          miscompares++;
          $display("FAIL rnd_resp k=%0d cyc=%0d: got data=%h err=%b expected data=%h err=%b",
                   k, c, rdata[k], err[k], ed, e.err);
        end
      end else begin
        vectors++;
        if (rdata[k] !== 32'h0 || err[k] !== 1'b0) begin
          miscompares++;
          $display("FAIL rnd_quiet k=%0d cyc=%0d: got data=%h err=%b expected 0 0",
                   k, c, rdata[k], err[k]);
        end
      end
      // Occupancy as seen purely from the DUT's own handshakes.
      outstanding = outstanding + ((gnt[k] === 1'b1) ? 1 : 0) - ((rvalid[k] === 1'b1) ? 1 : 0);
      vectors++;
      if (outstanding > depth || outstanding < 0) begin
        miscompares++;
        $display("FAIL rnd_occupancy k=%0d cyc=%0d: got %0d expected 0..%0d", k, c, outstanding, depth);
      end
      if (eg) begin
        e.idx  = a / 4;
        e.err  = (a % 4 != 0) || (a / 4 >= 1024);
        e.resp = ((c > last) ? c : last) + wait_c;
        last   = e.resp;
        exp_q.push_back(e);
      end
      if (lwe[k]) mm[k][laddr[k]] = lwdata[k];
      next_cycle();
    end
    req[k] = 1'b0;
    lwe[k] = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_drain k=%0d: got %0d responses missing expected 0", k, exp_q.size());
    end
  endtask

  // --------------------------------------------------------------------------
  // Sequence and final report
  // --------------------------------------------------------------------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k]    = 1'b0;
      addr[k]   = 32'h0;
      lwe[k]    = 1'b0;
      laddr[k]  = 10'd0;
      lwdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    preload_all();
    test_back_to_back();
    test_latency();
    test_error();
    test_load_collision();
    test_reset_mid();
    test_random(0, 5000, 1, 2);
    test_random(1, 5000, 3, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
